re_grid_mapper: RTL and testbench
=================================

// Module: re_grid_mapper
// PURPOSE
//  Parametrised PUSCH resource-element mapper, successor to the single-DMRS-symbol mapper.
//  Maps one slot (Sym_Start..Sym_End) of DMRS and FFT/data REs into the grid memory.
//  Adds per-symbol DMRS mask (multiple DMRS symbols), selectable comb offset, config
//  checking, valid/ready back-pressure on both sources, and abort.
//  Sits between the DMRS generator / transform-precoder FFT and the IFFT grid RAM.
// PARAMETERS
//  DATA_W   18    width of FFT_I/FFT_Q and RE_Real/RE_Imj (signed)
//  DMRS_W   9     width of Dmrs_I/Dmrs_Q (signed, sign-extended to DATA_W on output)
//  NSC_MAX  1200  total subcarriers in the grid
//  ADDR_W   11    grid address width; must satisfy 2**ADDR_W >= NSC_MAX
//  NSYM     14    symbols per slot
// PORTS
//  CLK_RE        in   1          clock
//  RST_RE        in   1          asynchronous, active-low reset
//  Cfg_Start     in   1          pulse in IDLE: latch config, start slot
//  Abort         in   1          synchronous; return to IDLE next cycle
//  N_sc          in   11         first allocated subcarrier
//  N_rb          in   7          allocated RBs (12 sc each)
//  Sym_Start     in   4          first symbol of allocation
//  Sym_End       in   4          last symbol (inclusive)
//  Dmrs_Mask     in   NSYM       bit s=1: symbol s carries DMRS
//  Comb_Off      in   1          DMRS on REs with k[0]==Comb_Off; other REs forced to 0
//  Dmrs_I/Q      in   DMRS_W     DMRS sample
//  Dmrs_Valid    in   1          DMRS sample present
//  Dmrs_Ready    out  1          DMRS sample consumed this cycle
//  FFT_I/Q       in   DATA_W     data sample
//  FFT_Valid     in   1          data sample present
//  FFT_Ready     out  1          data sample consumed this cycle
//  RE_Real/Imj   out  DATA_W     RE value to grid
//  RE_Valid      out  1          grid write strobe
//  Wr_addr       out  ADDR_W     subcarrier address = N_sc + k
//  Wr_sym        out  4          symbol index of this write
//  Sym_Done      out  1          pulse with last RE of each symbol
//  RE_Done       out  1          pulse with last RE of Sym_End
//  Cfg_Err       out  1          pulse: config rejected
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; k=0; config regs 0.
//  States: IDLE -> CHECK -> MAP -> (next symbol MAP | DONE) -> IDLE.
//  CHECK (1 cycle): error if N_rb==0, Sym_End<Sym_Start, Sym_End>=NSYM,
//   or N_sc+12*N_rb>NSC_MAX (compute in 12 bits) -> Cfg_Err=1 for 1 cycle, back to IDLE.
//  MAP: k counts 0..12*N_rb-1 in current symbol s; one RE per advance.
//   DMRS symbol (Dmrs_Mask[s]): k[0]==Comb_Off needs Dmrs_Valid (Dmrs_Ready=1),
//   else write zero without handshake; advance when the RE is written.
//   Data symbol: Dmrs_Ready=0; FFT_Ready=1 in MAP; advance on FFT_Valid&FFT_Ready.
//   No source valid -> stall, k held, RE_Valid=0. Ready never asserted outside MAP.
//  Outputs registered: RE_Valid/RE_*/Wr_addr/Wr_sym appear 1 cycle after acceptance.
//  Last k of symbol: Sym_Done with that RE_Valid; k->0, s->s+1; no idle cycle between symbols.
//  s==Sym_End last RE: RE_Done and Sym_Done together; -> DONE (1 cycle) -> IDLE.
//  Cfg_Start outside IDLE ignored. Config inputs sampled only on Cfg_Start.
//  Abort has priority over all transitions: readies drop same cycle, no further RE_Valid,
//   no Sym_Done/RE_Done; pending registered write of the abort cycle is suppressed.
//  DMRS sign-extended DMRS_W->DATA_W. Wr_addr never wraps (guaranteed by CHECK).
// STRUCTURE
//  Package re_mapper_pkg: state enum, SC_PER_RB=12, NSYM, NSC_MAX, config struct.
//  Sub-module re_addr_gen: k/s counters, Wr_addr adder, last-RE/last-symbol flags.
// TESTING
//  N_sc=0,N_rb=1,Sym 2..3,Mask=0x004,Comb=0 -> sym2: 6 DMRS at even addr, 0 at odd; sym3: 12 FFT at 0..11; RE_Done once.
//  N_sc=600,N_rb=50,Sym 0..13,Mask=0x0804 -> 14 Sym_Done, addresses 600..1199, DMRS on syms 2,11.
//  N_sc=1100,N_rb=10 -> Cfg_Err pulse, no RE_Valid, state IDLE; Sym_End=1,Sym_Start=3 -> Cfg_Err.
//  Random FFT_Valid gaps (50%) -> address sequence contiguous, RE count exact, no duplicates.
//  Comb_Off=1, N_sc=5 -> DMRS at 6,8,..; zeros at 5,7,..; Dmrs_Ready count = 6*N_rb.
//  Abort mid-symbol 4 at k=30, then Cfg_Start -> clean restart at k=0, Sym_Start; RST_RE mid-run -> all outputs 0.

Source files
------------

// File: rtl/re_mapper_pkg.sv
// Shared types and constants for the PUSCH resource-element grid mapper.
package re_mapper_pkg;

  localparam int unsigned SC_PER_RB = 12;
  localparam int unsigned NSYM      = 14;
  localparam int unsigned NSC_MAX   = 1200;
  // Config range check is done at this width so N_sc + 12*N_rb cannot overflow.
  localparam int unsigned CHK_W     = 12;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StMap,
    StDone
  } state_e;

  typedef struct packed {
    logic [6:0] n_rb;
    logic [3:0] sym_start;
    logic [3:0] sym_end;
    logic       comb_off;
  } re_cfg_t;

endpackage

// File: rtl/re_addr_gen.sv
// Subcarrier (k) and symbol (s) counters for the grid mapper, with grid address
// and end-of-symbol / end-of-slot flags.
module re_addr_gen #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              CLK_RE,
  input  logic              RST_RE,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] n_sc,
  input  logic [6:0]        n_rb,
  input  logic [3:0]        sym_start,
  input  logic [3:0]        sym_end,
  output logic              k_lsb,
  output logic [3:0]        s,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last_k,
  output logic              last_sym
);
  import re_mapper_pkg::SC_PER_RB;

  logic [ADDR_W-1:0] k_q, k_d, k_last;
  logic [3:0]        s_q, s_d;

  assign k_last = ADDR_W'(SC_PER_RB * n_rb) - ADDR_W'(1);

  always_comb begin
    k_d = k_q;
    s_d = s_q;
    if (load) begin
      k_d = '0;
      s_d = sym_start;
    end else if (advance) begin
      if (last_k) begin
        k_d = '0;
        s_d = s_q + 4'd1;
      end else begin
        k_d = k_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_RE or negedge RST_RE) begin
    if (!RST_RE) begin
      k_q <= '0;
      s_q <= '0;
    end else begin
      k_q <= k_d;
      s_q <= s_d;
    end
  end

  assign k_lsb    = k_q[0];
  assign s        = s_q;
  assign wr_addr  = n_sc + k_q;
  assign last_k   = (k_q == k_last);
  assign last_sym = (s_q == sym_end);

endmodule

// File: rtl/re_grid_mapper.sv
// PUSCH resource-element mapper: writes DMRS and data REs of one slot into the
// IFFT grid RAM, with per-symbol DMRS mask, comb offset, back-pressure and abort.
module re_grid_mapper #(
  parameter int unsigned DATA_W  = 18,
  parameter int unsigned DMRS_W  = 9,
  parameter int unsigned NSC_MAX = re_mapper_pkg::NSC_MAX,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned NSYM    = re_mapper_pkg::NSYM
) (
  input  logic                     CLK_RE,
  input  logic                     RST_RE,
  input  logic                     Cfg_Start,
  input  logic                     Abort,
  input  logic [ADDR_W-1:0]        N_sc,
  input  logic [6:0]               N_rb,
  input  logic [3:0]               Sym_Start,
  input  logic [3:0]               Sym_End,
  input  logic [NSYM-1:0]          Dmrs_Mask,
  input  logic                     Comb_Off,
  input  logic signed [DMRS_W-1:0] Dmrs_I,
  input  logic signed [DMRS_W-1:0] Dmrs_Q,
  input  logic                     Dmrs_Valid,
  output logic                     Dmrs_Ready,
  input  logic signed [DATA_W-1:0] FFT_I,
  input  logic signed [DATA_W-1:0] FFT_Q,
  input  logic                     FFT_Valid,
  output logic                     FFT_Ready,
  output logic signed [DATA_W-1:0] RE_Real,
  output logic signed [DATA_W-1:0] RE_Imj,
  output logic                     RE_Valid,
  output logic [ADDR_W-1:0]        Wr_addr,
  output logic [3:0]               Wr_sym,
  output logic                     Sym_Done,
  output logic                     RE_Done,
  output logic                     Cfg_Err
);
  import re_mapper_pkg::state_e;
  import re_mapper_pkg::re_cfg_t;
  import re_mapper_pkg::SC_PER_RB;
  import re_mapper_pkg::CHK_W;
  import re_mapper_pkg::StIdle;
  import re_mapper_pkg::StCheck;
  import re_mapper_pkg::StMap;
  import re_mapper_pkg::StDone;

  state_e            state_q;
  re_cfg_t           cfg_q;
  logic [ADDR_W-1:0] n_sc_q;
  logic [NSYM-1:0]   mask_q;

  logic              k_lsb, last_k, last_sym;
  logic [3:0]        s;
  logic [ADDR_W-1:0] wr_addr;
  logic              load, advance, in_map, dmrs_sym, comb_hit, cfg_bad;
  logic [CHK_W-1:0]  span;
  logic [DATA_W-1:0] re_real_d, re_imj_d;

  assign span    = CHK_W'(n_sc_q) + CHK_W'(SC_PER_RB * cfg_q.n_rb);
  assign cfg_bad = (cfg_q.n_rb == 7'd0) || (cfg_q.sym_end < cfg_q.sym_start) ||
                   (32'(cfg_q.sym_end) >= NSYM) || (32'(span) > NSC_MAX);

  assign in_map   = (state_q == StMap) && !Abort;
  assign dmrs_sym = mask_q[s];
  assign comb_hit = (k_lsb == cfg_q.comb_off);

  assign Dmrs_Ready = in_map && dmrs_sym && comb_hit;
  assign FFT_Ready  = in_map && !dmrs_sym;
  // Off-comb REs of a DMRS symbol are written as zero without waiting on any source.
  assign advance    = in_map && (dmrs_sym ? (!comb_hit || Dmrs_Valid) : FFT_Valid);
  assign load       = (state_q == StCheck) && !Abort && !cfg_bad;

  always_comb begin
    re_real_d = FFT_I;
    re_imj_d  = FFT_Q;
    if (dmrs_sym) begin
      re_real_d = '0;
      re_imj_d  = '0;
      if (comb_hit) begin
        re_real_d = {{(DATA_W-DMRS_W){Dmrs_I[DMRS_W-1]}}, Dmrs_I};
        re_imj_d  = {{(DATA_W-DMRS_W){Dmrs_Q[DMRS_W-1]}}, Dmrs_Q};
      end
    end
  end

  re_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .CLK_RE    (CLK_RE),
    .RST_RE    (RST_RE),
    .load      (load),
    .advance   (advance),
    .n_sc      (n_sc_q),
    .n_rb      (cfg_q.n_rb),
    .sym_start (cfg_q.sym_start),
    .sym_end   (cfg_q.sym_end),
    .k_lsb     (k_lsb),
    .s         (s),
    .wr_addr   (wr_addr),
    .last_k    (last_k),
    .last_sym  (last_sym)
  );

  always_ff @(posedge CLK_RE or negedge RST_RE) begin
    if (!RST_RE) begin
      state_q  <= StIdle;
      cfg_q    <= '0;
      n_sc_q   <= '0;
      mask_q   <= '0;
      RE_Valid <= 1'b0;
      RE_Real  <= '0;
      RE_Imj   <= '0;
      Wr_addr  <= '0;
      Wr_sym   <= '0;
      Sym_Done <= 1'b0;
      RE_Done  <= 1'b0;
      Cfg_Err  <= 1'b0;
    end else begin
      RE_Valid <= advance;
      Sym_Done <= advance && last_k;
      RE_Done  <= advance && last_k && last_sym;
      Cfg_Err  <= 1'b0;
      if (advance) begin
        RE_Real <= re_real_d;
        RE_Imj  <= re_imj_d;
        Wr_addr <= wr_addr;
        Wr_sym  <= s;
      end
      if (Abort) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (Cfg_Start) begin
              cfg_q.n_rb      <= N_rb;
              cfg_q.sym_start <= Sym_Start;
              cfg_q.sym_end   <= Sym_End;
              cfg_q.comb_off  <= Comb_Off;
              n_sc_q          <= N_sc;
              mask_q          <= Dmrs_Mask;
              state_q         <= StCheck;
            end
          end
          StCheck: begin
            if (cfg_bad) begin
              Cfg_Err <= 1'b1;
              state_q <= StIdle;
            end else begin
              state_q <= StMap;
            end
          end
          StMap: begin
            if (advance && last_k && last_sym) state_q <= StDone;
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_re_grid_mapper.sv
// Directed bench for re_grid_mapper: expected RE streams are built by a per-slot
// loop model and compared against writes captured from the grid port.
module tb_re_grid_mapper;
  localparam int DATA_W = 18;
  localparam int DMRS_W = 9;
  localparam int ADDR_W = 11;
  localparam int NSYM   = 14;

  logic CLK_RE = 1'b0;
  logic RST_RE = 1'b0;
  always #5 CLK_RE = ~CLK_RE;

  logic                     Cfg_Start, Abort, Comb_Off;
  logic [ADDR_W-1:0]        N_sc;
  logic [6:0]               N_rb;
  logic [3:0]               Sym_Start, Sym_End;
  logic [NSYM-1:0]          Dmrs_Mask;
  logic signed [DMRS_W-1:0] Dmrs_I, Dmrs_Q;
  logic                     Dmrs_Valid, Dmrs_Ready;
  logic signed [DATA_W-1:0] FFT_I, FFT_Q;
  logic                     FFT_Valid, FFT_Ready;
  logic signed [DATA_W-1:0] RE_Real, RE_Imj;
  logic                     RE_Valid;
  logic [ADDR_W-1:0]        Wr_addr;
  logic [3:0]               Wr_sym;
  logic                     Sym_Done, RE_Done, Cfg_Err;

  re_grid_mapper dut (
    .CLK_RE     (CLK_RE),
    .RST_RE     (RST_RE),
    .Cfg_Start  (Cfg_Start),
    .Abort      (Abort),
    .N_sc       (N_sc),
    .N_rb       (N_rb),
    .Sym_Start  (Sym_Start),
    .Sym_End    (Sym_End),
    .Dmrs_Mask  (Dmrs_Mask),
    .Comb_Off   (Comb_Off),
    .Dmrs_I     (Dmrs_I),
    .Dmrs_Q     (Dmrs_Q),
    .Dmrs_Valid (Dmrs_Valid),
    .Dmrs_Ready (Dmrs_Ready),
    .FFT_I      (FFT_I),
    .FFT_Q      (FFT_Q),
    .FFT_Valid  (FFT_Valid),
    .FFT_Ready  (FFT_Ready),
    .RE_Real    (RE_Real),
    .RE_Imj     (RE_Imj),
    .RE_Valid   (RE_Valid),
    .Wr_addr    (Wr_addr),
    .Wr_sym     (Wr_sym),
    .Sym_Done   (Sym_Done),
    .RE_Done    (RE_Done),
    .Cfg_Err    (Cfg_Err)
  );

  // Source samples are a function of how many have been consumed so far.
  int   dmrs_cnt = 0, fft_cnt = 0;
  logic dmrs_fire = 1'b0, fft_fire = 1'b0;
  assign Dmrs_I = DMRS_W'(-(dmrs_cnt + 1));
  assign Dmrs_Q = DMRS_W'(dmrs_cnt + 1);
  assign FFT_I  = DATA_W'(fft_cnt * 3 + 7);
  assign FFT_Q  = DATA_W'(-fft_cnt);

  function automatic logic [DATA_W-1:0] dmrs_re(int d);
    logic signed [DMRS_W-1:0] v;
    v = DMRS_W'(-(d + 1));
    return DATA_W'(v);
  endfunction
  function automatic logic [DATA_W-1:0] dmrs_im(int d);
    logic signed [DMRS_W-1:0] v;
    v = DMRS_W'(d + 1);
    return DATA_W'(v);
  endfunction

  logic [3:0]        q_sym[$], e_sym[$];
  logic [ADDR_W-1:0] q_addr[$], e_addr[$];
  logic [DATA_W-1:0] q_re[$], e_re[$], q_im[$], e_im[$];
  int n_symdone = 0, n_redone = 0, n_cfgerr = 0, n_dmrs_hs = 0;
  int checks = 0, failures = 0;

  always @(negedge CLK_RE) begin
    if (RE_Valid) begin
      q_sym.push_back(Wr_sym);
      q_addr.push_back(Wr_addr);
      q_re.push_back(RE_Real);
      q_im.push_back(RE_Imj);
    end
    if (Sym_Done) n_symdone++;
    if (RE_Done) n_redone++;
    if (Cfg_Err) n_cfgerr++;
    dmrs_fire = Dmrs_Valid && Dmrs_Ready;
    fft_fire  = FFT_Valid && FFT_Ready;
    if (dmrs_fire) n_dmrs_hs++;
  end

  always @(posedge CLK_RE) begin
    #1;
    if (dmrs_fire) dmrs_cnt++;
    if (fft_fire) fft_cnt++;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    q_sym.delete(); q_addr.delete(); q_re.delete(); q_im.delete();
    e_sym.delete(); e_addr.delete(); e_re.delete(); e_im.delete();
    n_symdone = 0; n_redone = 0; n_cfgerr = 0; n_dmrs_hs = 0;
  endtask

  task automatic build_exp(int nsc, int nrb, int ss, int se, logic [NSYM-1:0] mask, int comb);
    int d = dmrs_cnt;
    int f = fft_cnt;
    for (int s = ss; s <= se; s++) begin
      for (int k = 0; k < 12 * nrb; k++) begin
        e_sym.push_back(4'(s));
        e_addr.push_back(ADDR_W'(nsc + k));
        if (mask[s]) begin
          if (k % 2 == comb) begin
            e_re.push_back(dmrs_re(d));
            e_im.push_back(dmrs_im(d));
            d++;
          end else begin
            e_re.push_back('0);
            e_im.push_back('0);
          end
        end else begin
          e_re.push_back(DATA_W'(f * 3 + 7));
          e_im.push_back(DATA_W'(-f));
          f++;
        end
      end
    end
  endtask

  // Config is only valid around the pulse; afterwards it is scrambled.
  task automatic start(int nsc, int nrb, int ss, int se, logic [NSYM-1:0] mask, logic comb);
    @(posedge CLK_RE); #1;
    N_sc = ADDR_W'(nsc); N_rb = 7'(nrb); Sym_Start = 4'(ss); Sym_End = 4'(se);
    Dmrs_Mask = mask; Comb_Off = comb; Cfg_Start = 1'b1;
    @(posedge CLK_RE); #1;
    Cfg_Start = 1'b0;
    N_sc = '1; N_rb = 7'h7f; Sym_Start = 4'hf; Sym_End = 4'h0; Dmrs_Mask = '1; Comb_Off = ~comb;
  endtask

  task automatic wait_done(string tag, int budget, bit rnd, bit poke);
    int n = 0;
    while (n_redone == 0 && n < budget) begin
      @(posedge CLK_RE); #1;
      n++;
      if (rnd) FFT_Valid = 1'($urandom_range(0, 1));
      if (poke) Cfg_Start = (n == 10);
    end
    FFT_Valid = 1'b1;
    Cfg_Start = 1'b0;
    chk({tag, " finished_in_budget"}, 32'(n < budget), 32'd1);
    repeat (4) @(posedge CLK_RE);
  endtask

  task automatic verify(string tag, int n_exp);
    int n;
    chk({tag, " re_count"}, q_addr.size(), n_exp);
    n = (q_addr.size() < n_exp) ? q_addr.size() : n_exp;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s addr[%0d]", tag, i), 32'(q_addr[i]), 32'(e_addr[i]));
      chk($sformatf("%s sym[%0d]", tag, i), 32'(q_sym[i]), 32'(e_sym[i]));
      chk($sformatf("%s re[%0d]", tag, i), 32'(q_re[i]), 32'(e_re[i]));
      chk($sformatf("%s im[%0d]", tag, i), 32'(q_im[i]), 32'(e_im[i]));
    end
  endtask

  int bad_sc[4]  = '{1100, 0, 0, 0};
  int bad_rb[4]  = '{10, 1, 0, 1};
  int bad_ss[4]  = '{0, 3, 0, 0};
  int bad_se[4]  = '{13, 1, 0, 14};

  initial begin
    Cfg_Start = 0; Abort = 0; Comb_Off = 0; N_sc = 0; N_rb = 0; Sym_Start = 0; Sym_End = 0;
    Dmrs_Mask = 0; Dmrs_Valid = 1; FFT_Valid = 1;
    repeat (3) @(posedge CLK_RE);
    #1;
    chk("rst RE_Valid", 32'(RE_Valid), 32'd0);
    chk("rst Wr_addr", 32'(Wr_addr), 32'd0);
    chk("rst RE_Real", 32'(RE_Real), 32'd0);
    chk("rst Sym_Done", 32'(Sym_Done), 32'd0);
    chk("rst RE_Done", 32'(RE_Done), 32'd0);
    chk("rst Cfg_Err", 32'(Cfg_Err), 32'd0);
    chk("rst Dmrs_Ready", 32'(Dmrs_Ready), 32'd0);
    chk("rst FFT_Ready", 32'(FFT_Ready), 32'd0);
    RST_RE = 1'b1;

    // One RB, DMRS symbol 2 (comb 0) then data symbol 3.
    clear_mon();
    build_exp(0, 1, 2, 3, 14'h004, 0);
    start(0, 1, 2, 3, 14'h004, 1'b0);
    wait_done("t1", 200, 0, 0);
    verify("t1", 24);
    chk("t1 sym_done", n_symdone, 2);
    chk("t1 re_done", n_redone, 1);
    chk("t1 idle FFT_Ready", 32'(FFT_Ready), 32'd0);

    // Full slot, upper half of the grid, DMRS on symbols 2 and 11.
    clear_mon();
    build_exp(600, 50, 0, 13, 14'h0804, 0);
    start(600, 50, 0, 13, 14'h0804, 1'b0);
    wait_done("t2", 9000, 0, 0);
    verify("t2", 8400);
    chk("t2 sym_done", n_symdone, 14);
    chk("t2 re_done", n_redone, 1);
    chk("t2 dmrs_hs", n_dmrs_hs, 600);

    // Rejected configurations.
    for (int i = 0; i < 4; i++) begin
      clear_mon();
      start(bad_sc[i], bad_rb[i], bad_ss[i], bad_se[i], 14'h0, 1'b0);
      repeat (5) @(posedge CLK_RE);
      #1;
      chk($sformatf("bad%0d cfg_err", i), n_cfgerr, 1);
      chk($sformatf("bad%0d no_writes", i), q_addr.size(), 0);
      chk($sformatf("bad%0d FFT_Ready", i), 32'(FFT_Ready), 32'd0);
    end

    // Allocation ending exactly at the top of the grid is accepted.
    clear_mon();
    build_exp(1080, 10, 13, 13, 14'h0, 0);
    start(1080, 10, 13, 13, 14'h0, 1'b0);
    wait_done("edge", 300, 0, 0);
    verify("edge", 120);
    chk("edge cfg_err", n_cfgerr, 0);

    // Random data gaps plus an ignored Cfg_Start mid-run.
    clear_mon();
    build_exp(100, 2, 5, 6, 14'h0, 0);
    start(100, 2, 5, 6, 14'h0, 1'b0);
    wait_done("rand", 600, 1, 1);
    verify("rand", 48);
    chk("rand sym_done", n_symdone, 2);

    // Comb offset 1 from an odd starting subcarrier.
    clear_mon();
    build_exp(5, 2, 4, 4, 14'h010, 1);
    start(5, 2, 4, 4, 14'h010, 1'b1);
    wait_done("comb", 200, 0, 0);
    verify("comb", 24);
    chk("comb dmrs_hs", n_dmrs_hs, 12);

    // Abort mid symbol 4: the RE already accepted is the last one written.
    clear_mon();
    build_exp(0, 4, 4, 5, 14'h0, 0);
    start(0, 4, 4, 5, 14'h0, 1'b0);
    for (int n = 0; q_addr.size() < 30 && n < 200; n++) @(posedge CLK_RE);
    #1 Abort = 1'b1;
    #1;
    chk("abort FFT_Ready", 32'(FFT_Ready), 32'd0);
    chk("abort Dmrs_Ready", 32'(Dmrs_Ready), 32'd0);
    @(posedge CLK_RE); #1 Abort = 1'b0;
    repeat (6) @(posedge CLK_RE);
    verify("abort", 31);
    chk("abort sym_done", n_symdone, 0);
    chk("abort re_done", n_redone, 0);

    clear_mon();
    build_exp(0, 1, 4, 4, 14'h0, 0);
    start(0, 1, 4, 4, 14'h0, 1'b0);
    wait_done("restart", 100, 0, 0);
    verify("restart", 12);

    // Asynchronous reset in the middle of a run.
    clear_mon();
    start(0, 2, 0, 1, 14'h001, 1'b0);
    repeat (10) @(posedge CLK_RE);
    #1 RST_RE = 1'b0;
    #1;
    chk("mrst RE_Valid", 32'(RE_Valid), 32'd0);
    chk("mrst Wr_addr", 32'(Wr_addr), 32'd0);
    chk("mrst Wr_sym", 32'(Wr_sym), 32'd0);
    chk("mrst RE_Real", 32'(RE_Real), 32'd0);
    chk("mrst RE_Imj", 32'(RE_Imj), 32'd0);
    chk("mrst Sym_Done", 32'(Sym_Done), 32'd0);
    chk("mrst FFT_Ready", 32'(FFT_Ready), 32'd0);
    chk("mrst Dmrs_Ready", 32'(Dmrs_Ready), 32'd0);
    repeat (2) @(posedge CLK_RE);
    #1 RST_RE = 1'b1;

    clear_mon();
    build_exp(0, 1, 7, 7, 14'h0, 0);
    start(0, 1, 7, 7, 14'h0, 1'b0);
    wait_done("post_rst", 100, 0, 0);
    verify("post_rst", 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
